// File: rtl/secded_pkg.sv
// Shared types and width helpers for the SECDED stream decoder.
package secded_pkg;

  typedef enum logic [1:0] {
    CLEAN = 2'b00,
    CORR  = 2'b01,
    DBL   = 2'b10
  } status_e;

  function automatic int unsigned cw_of(input int unsigned p);
    return 32'd1 << p;
  endfunction

  function automatic int unsigned dw_of(input int unsigned p);
    return (32'd1 << p) - p - 32'd1;
  endfunction

  // Codeword position of data bit j: the j-th non-power-of-two position above 2.
  function automatic int unsigned data_pos(input int unsigned p, input int unsigned j);
    int unsigned n;
    int unsigned pos;
    n   = 0;
    pos = 0;
    for (int unsigned i = 3; i < (32'd1 << p); i++) begin
      if ((i & (i - 32'd1)) != 0) begin
        if (n == j) pos = i;
        n++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of one codeword.
module secded_syndrome
  import secded_pkg::*;
#(
  parameter int unsigned P = 4
) (
  input  logic [cw_of(P)-1:0] code,
  output logic [P-1:0]        s,
  output logic                q
);

  localparam int unsigned CW = cw_of(P);

  always_comb begin
    s = '0;
    for (int unsigned i = 1; i < CW; i++) begin
      if (code[i]) s = s ^ P'(i);
    end
    q = ^code;
  end

endmodule

// File: rtl/secded_stream_dec.sv
// Two-stage SECDED decoder with valid/ready handshake and per-status counters.
module secded_stream_dec
  import secded_pkg::*;
#(
  parameter int unsigned P     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [cw_of(P)-1:0] in_code,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [cw_of(P)-1:0] out_word,
  input  logic                clr_cnt,
  output logic [CNT_W-1:0]    cnt_clean,
  output logic [CNT_W-1:0]    cnt_corr,
  output logic [CNT_W-1:0]    cnt_dbl
);

  localparam int unsigned CW = cw_of(P);
  localparam int unsigned DW = dw_of(P);

  logic [P-1:0]    syn;
  logic            par;
  logic            s1_valid_q, s1_valid_d;
  logic [CW-1:0]   s1_code_q, s1_code_d;
  logic [P-1:0]    s1_syn_q, s1_syn_d;
  logic            s1_par_q, s1_par_d;
  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   out_word_q, out_word_d;
  logic [CNT_W-1:0] cnt_clean_q, cnt_clean_d;
  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0] cnt_dbl_q, cnt_dbl_d;

  logic            adv2;
  logic            in_xfer;
  logic            out_xfer;
  logic [CW-1:0]   fixed;
  logic [DW-1:0]   data;
  status_e         status;

  secded_syndrome #(.P(P)) u_syndrome (
    .code (in_code),
    .s    (syn),
    .q    (par)
  );

  for (genvar g = 0; g < DW; g++) begin : g_extract
    assign data[g] = fixed[data_pos(P, g)];
  end

  always_comb begin
    adv2     = s1_valid_q && (!out_valid_q || out_ready);
    // Registers are already clear during reset; gating keeps in_ready low too.
    in_ready = reset && (!s1_valid_q || adv2);
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid_q && out_ready;

    fixed = s1_code_q;
    if (s1_par_q) fixed[s1_syn_q] = ~fixed[s1_syn_q];

    if (s1_par_q)            status = CORR;
    else if (s1_syn_q != '0) status = DBL;
    else                     status = CLEAN;

    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_code_d  = in_code;
      s1_syn_d   = syn;
      s1_par_d   = par;
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    if (adv2) begin
      out_valid_d              = 1'b1;
      out_word_d               = '0;
      out_word_d[CW-1 -: 2]    = status;
      out_word_d[DW-1:0]       = data;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    cnt_clean_d = cnt_clean_q;
    cnt_corr_d  = cnt_corr_q;
    cnt_dbl_d   = cnt_dbl_q;
    if (clr_cnt) begin
      cnt_clean_d = '0;
      cnt_corr_d  = '0;
      cnt_dbl_d   = '0;
    end else if (out_xfer) begin
      case (status_e'(out_word_q[CW-1 -: 2]))
        CLEAN:   if (cnt_clean_q != '1) cnt_clean_d = cnt_clean_q + 1'b1;
        CORR:    if (cnt_corr_q != '1)  cnt_corr_d  = cnt_corr_q + 1'b1;
        DBL:     if (cnt_dbl_q != '1)   cnt_dbl_d   = cnt_dbl_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s1_syn_q    <= '0;
      s1_par_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      cnt_clean_q <= '0;
      cnt_corr_q  <= '0;
      cnt_dbl_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      s1_syn_q    <= s1_syn_d;
      s1_par_q    <= s1_par_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      cnt_clean_q <= cnt_clean_d;
      cnt_corr_q  <= cnt_corr_d;
      cnt_dbl_q   <= cnt_dbl_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign cnt_clean = cnt_clean_q;
  assign cnt_corr  = cnt_corr_q;
  assign cnt_dbl   = cnt_dbl_q;

endmodule
